instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle control unit.
- Holds the PC and fetches 32-bit instructions from an instruction memory using a req/ready handshake.
- Presents the instruction register and its decoded fields (op, func, rs, rt, rd, imm16, target) to the decode/control logic.
- Computes the next PC from the Branch, Jump and ALU Zero results fed back for the current instruction.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC and imem address width. Fixed at 32 in this revision.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous, active-high reset.
- imem_req, output, 1, fetch request to instruction memory.
- imem_addr, output, 32, byte address; always equals pc.
- imem_ready, input, 1, imem_rdata is valid this cycle.
- imem_rdata, input, 32, instruction word.
- stall, input, 1, downstream cannot accept retirement this cycle.
- branch, input, 1, Branch from control unit for the current instruction.
- jump, input, 1, Jump from control unit.
- zero, input, 1, ALU Zero flag.
- instr_valid, output, 1, ir holds a valid instruction.
- pc, output, 32, address of the instruction in ir.
- ir, output, 32, instruction register.
- op, output, 6, ir[31:26].
- rs, output, 5, ir[25:21].
- rt, output, 5, ir[20:16].
- rd, output, 5, ir[15:11].
- func, output, 6, ir[5:0].
- imm16, output, 16, ir[15:0].
- target, output, 26, ir[25:0].
- perf_fetched, output, 32, retired-instruction count (see optional feature).
- perf_wait, output, 32, imem wait-cycle count (see optional feature).

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - pc <= PC_RESET, ir <= 0, state <= S_FETCH, counters <= 0.
  - instr_valid = 0 and imem_req = 0 while reset is high and in the cycle it is sampled.
- FSM states:
  - S_FETCH: imem_req = 1, imem_addr = pc, instr_valid = 0.
    - If imem_ready: ir <= imem_rdata; go to S_VALID.
    - Else stay in S_FETCH. req and addr are held stable; one wait cycle is counted.
  - S_VALID: instr_valid = 1, imem_req = 0.
    - advance = ~stall.
    - On advance: pc <= next_pc; go to S_FETCH.
    - Else hold pc, ir and state.
- Latency: first imem_req appears the cycle after reset deasserts. Minimum 2 cycles per instruction (1 fetch + 1 valid).
- Decoded outputs are combinational slices of ir and change only when ir loads.
- branch, jump and zero are sampled only on advance and are ignored otherwise.
- next_pc, all arithmetic modulo 2^32:
  - pc4 = pc + 4.
  - If jump: next_pc = {pc4[31:28], target, 2'b00}. Jump has priority over branch.
  - Else if branch & zero: next_pc = pc4 + (sign_ext32(imm16) << 2).
  - Else: next_pc = pc4.
- imem_ready outside S_FETCH is ignored; imem_rdata is don't-care.
- Reset mid-operation (S_FETCH wait or stalled S_VALID) abandons the fetch. The memory must also be reset in the same cycle; there is no outstanding-request tracking.
- pc = 32'hFFFF_FFFC with no branch/jump wraps to 32'h0000_0000.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on every advance.
  - perf_wait increments every S_FETCH cycle with imem_ready = 0.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package ifu_pkg holds:
  - the FSM state enum (S_FETCH, S_VALID);
  - default PC_RESET;
  - field bit positions (OP_HI/LO, RS, RT, RD, FUNC, IMM, TARGET).
- One combinational sub-module, ifu_next_pc (pc, imm16, target, branch, zero, jump -> next_pc), for isolated verification.

Test Plan:
- Reset, imem_ready=1, imem_rdata=32'h2008_0005:
  - imem_req=1 with imem_addr=32'h0000_3000 in cycle 1 after reset.
  - Next cycle: instr_valid=1, op=6'h08, rt=5'd8, imm16=16'h0005.
- pc=32'h0000_3004, imm16=16'hFFFF, branch=1, zero=1, advance -> next imem_addr=32'h0000_3004. Repeat with zero=0 -> 32'h0000_3008.
- pc=32'h0000_3000, target=26'h000_0C10, jump=1, branch=1, zero=1 -> next imem_addr=32'h0000_3040.
- imem_ready held low 4 cycles in S_FETCH:
  - imem_req stays 1 and imem_addr stays stable for 4 cycles; instr_valid stays 0.
  - Capture on cycle 5; perf_wait=4 with IFU_PERF_CNT_EN.
- stall=1 for 3 cycles in S_VALID:
  - pc, ir and instr_valid=1 held; imem_req=0; branch/jump toggling has no effect.
  - After stall drops, fetch resumes from pc+4.
- reset during a stalled S_VALID at pc=32'h0000_3010:
  - Next cycle pc=32'h0000_3000, instr_valid=0, ir=0, perf counters=0.
  - Then imem_req=1 at 32'h0000_3000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Field positions follow the MIPS-style R/I/J instruction layouts.
package ifu_pkg;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } ifu_state_e;

    localparam logic [31:0] IFU_PC_RESET = 32'h0000_3000;

    localparam int OP_HI     = 31;
    localparam int OP_LO     = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int FUNC_HI   = 5;
    localparam int FUNC_LO   = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int TARGET_HI = 25;
    localparam int TARGET_LO = 0;

    // Branch offsets are word counts; this yields the byte offset.
    function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC selection: jump > taken branch > sequential.
// Purely combinational; all arithmetic wraps modulo 2^32.
module ifu_next_pc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] target,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;

    always_comb begin
        pc4 = pc + 32'd4;
        if (jump) begin
            next_pc = {pc4[31:28], target, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc4 + branch_byte_offset(imm16);
        end else begin
            next_pc = pc4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ready fetch from imem, instruction register.
// Optional performance counters are built only when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = IFU_PC_RESET,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        func,
    output logic [15:0]       imm16,
    output logic [25:0]       target,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_wait,
    output logic              state_dbg
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] next_pc;
    logic        fetch_wait;
    logic        advance;

    ifu_next_pc u_next_pc (
        .pc      (pc_q),
        .imm16   (ir_q[IMM_HI:IMM_LO]),
        .target  (ir_q[TARGET_HI:TARGET_LO]),
        .branch  (branch),
        .zero    (zero),
        .jump    (jump),
        .next_pc (next_pc)
    );

    // branch/jump/zero only matter on the advance edge, via next_pc.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        fetch_wait = 1'b0;
        advance    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_VALID;
                end else begin
                    fetch_wait = 1'b1;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    advance = 1'b1;
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] wait_q, wait_d;

    always_comb begin
        fetched_d = fetched_q + {31'd0, advance};
        wait_d    = wait_q + {31'd0, fetch_wait};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= 32'h0;
            wait_q    <= 32'h0;
        end else begin
            fetched_q <= fetched_d;
            wait_q    <= wait_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_wait    = wait_q;
`else
    logic unused_perf;
    assign unused_perf  = fetch_wait ^ advance;
    assign perf_fetched = 32'h0;
    assign perf_wait    = 32'h0;
`endif

    // Outputs are forced idle while reset is asserted, even before it is sampled.
    assign imem_req    = (state_q == S_FETCH) && !reset;
    assign instr_valid = (state_q == S_VALID) && !reset;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign state_dbg   = state_q;

    assign op     = ir_q[OP_HI:OP_LO];
    assign rs     = ir_q[RS_HI:RS_LO];
    assign rt     = ir_q[RT_HI:RT_LO];
    assign rd     = ir_q[RD_HI:RD_LO];
    assign func   = ir_q[FUNC_HI:FUNC_LO];
    assign imm16  = ir_q[IMM_HI:IMM_LO];
    assign target = ir_q[TARGET_HI:TARGET_LO];

endmodule
